capture_sequencer: RTL

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_pkg.sv | 41 ++++
 rtl/trig_detect.sv | 38 +++
 rtl/capture_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared FSM states, address width
// and modulo-DEPTH pointer arithmetic.
package capture_pkg;

  localparam int ADDR_W = 10;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [2:0]        state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRE   = 3'd1;
  localparam state_t ST_ARMED = 3'd2;
  localparam state_t ST_POST  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // (a + b) mod depth, with a, b < depth.
  function automatic addr_t wrap_add(
    input addr_t a,
    input addr_t b,
    input cnt_t  depth
  );
    cnt_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= depth) s = s - depth;
    return s[ADDR_W-1:0];
  endfunction

  // (a - b) mod depth, with a, b < depth.
  function automatic addr_t wrap_sub(
    input addr_t a,
    input addr_t b,
    input cnt_t  depth
  );
    cnt_t d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + depth - {1'b0, b};
    return d[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/trig_detect.sv
// trig_detect: remembers the previous sample and
// flags a level crossing on the current tick.
module trig_detect
  import capture_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  output logic                edge_hit
);

  logic [SAMPLE_W-1:0] prev;

  // Track the last sample seen on any tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         prev <= '0;
    else if (sample_tick) prev <= sample_data;
  end

  // Crossing test between prev and the live sample.
  always_comb begin
    edge_hit = 1'b0;
    if (sample_tick) begin
      if (trig_falling)
        edge_hit = (prev >= trig_level) &&
                   (trig_level > sample_data);
      else
        edge_hit = (prev < trig_level) &&
                   (trig_level <= sample_data);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: pre/post-trigger frame capture.
// Define CAPTURE_AUTO_TRIG_EN for timeout-forced capture.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SAMPLE_W     = 12,
  parameter int DEPTH        = 640,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 2048
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic                single,
  input  logic                arm,
  input  logic                hold,
  input  logic                frame_ack,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic [ADDR_W-1:0]   start_addr,
  output logic                frame_valid,
  output logic                triggered,
  output logic                busy
);

  localparam cnt_t  DEPTH_C   = cnt_t'(DEPTH);
  localparam addr_t PRE_C     = addr_t'(PRETRIG);
  localparam addr_t PRE_LAST  = addr_t'(PRETRIG - 1);
  localparam addr_t POST_LAST = addr_t'(DEPTH - PRETRIG - 1);

  state_t state;
  logic   boot;
  addr_t  wptr;
  addr_t  trig_addr;
  addr_t  pre_cnt;
  addr_t  post_cnt;
  logic   edge_hit;
  logic   to_hit;
  logic   capturing;

  assign capturing = (state == ST_PRE) ||
                     (state == ST_ARMED) ||
                     (state == ST_POST);
  assign busy = capturing;

  trig_detect #(
    .SAMPLE_W(SAMPLE_W)
  ) u_trig (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .edge_hit     (edge_hit)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(AUTO_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  // Ticks spent in ARMED; zero on every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               to_cnt <= '0;
    else if (state != ST_ARMED) to_cnt <= '0;
    else if (sample_tick)       to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = sample_tick && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Sample buffer write port, one cycle behind the tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wptr    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (sample_tick && capturing) begin
        wr_en   <= 1'b1;
        wr_addr <= wptr;
        wr_data <= sample_data;
        wptr    <= wrap_add(wptr, addr_t'(1), DEPTH_C);
      end
    end
  end

  // Frame FSM: fill history, hunt trigger, fill tail, hand off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      boot        <= 1'b1;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trig_addr   <= '0;
      start_addr  <= '0;
      frame_valid <= 1'b0;
      triggered   <= 1'b0;
    end else begin
      boot <= 1'b0;
      if (arm && (state != ST_IDLE)) begin
        state       <= ST_PRE;
        pre_cnt     <= '0;
        triggered   <= 1'b0;
        frame_valid <= 1'b0;
      end else begin
        unique case (1'b1)
          (state == ST_IDLE): begin
            if (boot || (arm && single)) begin
              state     <= ST_PRE;
              pre_cnt   <= '0;
              triggered <= 1'b0;
            end
          end
          (state == ST_PRE): begin
            if (sample_tick) begin
              if (pre_cnt == PRE_LAST) begin
                state   <= ST_ARMED;
                pre_cnt <= '0;
              end else begin
                pre_cnt <= pre_cnt + 1'b1;
              end
            end
          end
          (state == ST_ARMED): begin
            if (sample_tick && (edge_hit || to_hit)) begin
              trig_addr <= wptr;
              triggered <= edge_hit;
              if (POST_LAST == '0) begin
                state       <= ST_DONE;
                frame_valid <= 1'b1;
                start_addr  <=
                  wrap_sub(wptr, PRE_C, DEPTH_C);
              end else begin
                state    <= ST_POST;
                post_cnt <= addr_t'(1);
              end
            end
          end
          (state == ST_POST): begin
            if (sample_tick) begin
              if (post_cnt == POST_LAST) begin
                state       <= ST_DONE;
                frame_valid <= 1'b1;
                start_addr  <=
                  wrap_sub(trig_addr, PRE_C, DEPTH_C);
              end else begin
                post_cnt <= post_cnt + 1'b1;
              end
            end
          end
          (state == ST_DONE): begin
            if (frame_ack && !hold) begin
              frame_valid <= 1'b0;
              if (single) begin
                state <= ST_IDLE;
              end else begin
                state     <= ST_PRE;
                pre_cnt   <= '0;
                triggered <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
